trace_rle_buffer: RTL and testbench

TRACE_RLE_BUFFER -- requirements
Module: trace_rle_buffer

---
 rtl/trace_pkg.sv | 17 +
 rtl/trace_fifo.sv | 41 ++++
 rtl/trace_rle_buffer.sv | 97 +++++++++
 tb/tb_trace_rle_buffer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: register map, ID constant and entry sizing for the trace run-length buffer
package trace_pkg;
   localparam logic [31:0] TRACE_ID = 32'h5452_4C45;
   localparam int DATA_W = 32;
   localparam logic [2:0] ADDR_ID = 3'd0;
   localparam logic [2:0] ADDR_HEAD_DATA = 3'd1;
   localparam logic [2:0] ADDR_HEAD_CNT = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_DROP = 3'd4;
   localparam logic [2:0] ADDR_CTRL = 3'd5;
   localparam logic [2:0] ADDR_RSVD = 3'd6;
   localparam logic [2:0] ADDR_CLEAR = 3'd7;
   typedef enum logic [2:0] {RUN_IDLE, RUN_OPEN, RUN_EXTEND, RUN_SPLIT, RUN_FLUSH} run_act_e;
   function automatic int entry_w(input int cnt_w);
      return DATA_W + cnt_w;
   endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with unreset storage and a level counter
module trace_fifo #(
   parameter int DEPTH_LOG2 = 8,
   parameter int WIDTH = 48
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  full,
   output logic                  empty
);
   localparam int PW = DEPTH_LOG2;
   localparam int LW = DEPTH_LOG2 + 1;
   logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];
   logic [PW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         level <= level + LW'(push) - LW'(pop);
      end
   end
   assign rdata = mem[rd_ptr];
   assign full = level[DEPTH_LOG2];
   assign empty = level == '0;
endmodule

// File: rtl/trace_rle_buffer.sv
// trace_rle_buffer: run-length encodes qualified trace samples into a debug-readable FIFO
module trace_rle_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_trace_data,
   input  logic        i_trace_en,
   input  logic        i_dbg_rd,
   input  logic        i_dbg_wr,
   input  logic [2:0]  i_dbg_addr,
   input  logic [31:0] i_dbg_wdata,
   output logic [31:0] o_dbg_rdata,
   output logic        o_full,
   output logic        o_overflow
);
   localparam int EW = entry_w(CNT_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   logic arm, run_open, cap, clr, pop, push, push_req, drop, fifo_empty, unused_ok;
   logic [31:0] run_data, drop_cnt;
   logic [CNT_WIDTH-1:0] run_cnt;
   logic [DEPTH_LOG2:0] level;
   logic [EW-1:0] head;
   run_act_e act;
   assign unused_ok = ^{i_dbg_rd, i_dbg_wdata[31:1]};
   assign cap = arm & i_trace_en;
   assign clr = i_dbg_wr && i_dbg_addr == ADDR_CLEAR;
   always_comb
      act = !cap ? (run_open ? RUN_FLUSH : RUN_IDLE) :
            !run_open ? RUN_OPEN :
            (i_trace_data == run_data && run_cnt != CNT_MAX) ? RUN_EXTEND : RUN_SPLIT;
   assign push_req = (act == RUN_FLUSH || act == RUN_SPLIT) && !clr;
   assign pop = i_dbg_wr && i_dbg_addr == ADDR_HEAD_DATA && !fifo_empty && !clr;
   // A pop frees a slot on the same edge, so a full FIFO still accepts the push
   assign push = push_req && (!o_full || pop);
   assign drop = push_req && !push;
   trace_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(EW)) u_fifo (
      .clk(clk),
      .reset(reset),
      .clr(clr),
      .push(push),
      .pop(pop),
      .wdata({run_data, run_cnt}),
      .rdata(head),
      .level(level),
      .full(o_full),
      .empty(fifo_empty)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         arm <= 1'b0;
         run_open <= 1'b0;
         run_data <= '0;
         run_cnt <= '0;
         o_overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (i_dbg_wr && i_dbg_addr == ADDR_CTRL) arm <= i_dbg_wdata[0];
         if (clr) begin
            run_open <= 1'b0;
            o_overflow <= 1'b0;
            drop_cnt <= '0;
         end else begin
            if (act == RUN_OPEN || act == RUN_SPLIT) begin
               run_open <= 1'b1;
               run_data <= i_trace_data;
               run_cnt <= CNT_WIDTH'(1);
            end else if (act == RUN_EXTEND) begin
               run_cnt <= run_cnt + CNT_WIDTH'(1);
            end else if (act == RUN_FLUSH) begin
               run_open <= 1'b0;
            end
            if (drop) begin
               o_overflow <= 1'b1;
               if (drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
            end
         end
      end
   end
   always_comb begin
      o_dbg_rdata = '1;
      case (i_dbg_addr)
         ADDR_ID:        o_dbg_rdata = TRACE_ID;
         ADDR_HEAD_DATA: o_dbg_rdata = fifo_empty ? '1 : head[EW-1:CNT_WIDTH];
         ADDR_HEAD_CNT:  o_dbg_rdata = fifo_empty ? '0 : 32'(head[CNT_WIDTH-1:0]);
         ADDR_STATUS:    o_dbg_rdata = {o_overflow, 31'(level)};
         ADDR_DROP:      o_dbg_rdata = drop_cnt;
         ADDR_CTRL:      o_dbg_rdata = {31'b0, arm};
         ADDR_RSVD:      o_dbg_rdata = '1;
         ADDR_CLEAR:     o_dbg_rdata = '1;
         default:        o_dbg_rdata = '1;
      endcase
   end
endmodule

// File: tb/tb_trace_rle_buffer.sv
// tb_trace_rle_buffer: vector table, corner sequences and randomized traffic against a queue-based model
module tb_trace_rle_buffer;
   localparam int DL = 2;
   localparam int CW = 4;
   localparam int DEPTH = 1 << DL;
   localparam int CMAX = (1 << CW) - 1;

   logic clk, reset;
   logic [31:0] i_trace_data, i_dbg_wdata, o_dbg_rdata;
   logic i_trace_en, i_dbg_rd, i_dbg_wr, o_full, o_overflow;
   logic [2:0] i_dbg_addr;

   trace_rle_buffer #(.DEPTH_LOG2(DL), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .i_trace_data(i_trace_data), .i_trace_en(i_trace_en),
      .i_dbg_rd(i_dbg_rd), .i_dbg_wr(i_dbg_wr), .i_dbg_addr(i_dbg_addr),
      .i_dbg_wdata(i_dbg_wdata), .o_dbg_rdata(o_dbg_rdata), .o_full(o_full),
      .o_overflow(o_overflow)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   typedef struct {logic [31:0] d; int c;} ent_t;
   ent_t m_q[$];
   bit m_arm, m_open, m_ovf;
   logic [31:0] m_data, m_drop;
   int m_cnt;
   int checks = 0, errors = 0;

   typedef struct {
      logic en; logic [31:0] d; logic wr; logic [2:0] a; logic [31:0] wd;
      logic [2:0] ra; logic [31:0] exp;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_reg(input int a);
      case (a)
         0: return 32'h5452_4C45;
         1: return m_q.size() != 0 ? m_q[0].d : 32'hFFFF_FFFF;
         2: return m_q.size() != 0 ? 32'(m_q[0].c) : 32'h0;
         3: return {m_ovf, 31'(m_q.size())};
         4: return m_drop;
         5: return {31'b0, m_arm};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_arm = 0; m_open = 0; m_ovf = 0; m_drop = 0; m_cnt = 0; m_data = 0;
   endtask

   task automatic model_edge(input bit en, input logic [31:0] d, input bit wr, input logic [2:0] a, input logic [31:0] wd);
      bit clr, pop, cap, do_push;
      ent_t pe;
      clr = wr && a == 7;
      pop = wr && a == 1 && m_q.size() != 0 && !clr;
      cap = m_arm && en;
      do_push = 0;
      if (clr) begin
         m_q.delete(); m_open = 0; m_ovf = 0; m_drop = 0;
      end else begin
         if (cap && !m_open) begin
            m_open = 1; m_data = d; m_cnt = 1;
         end else if (cap && d == m_data && m_cnt < CMAX) begin
            m_cnt++;
         end else if (cap) begin
            do_push = 1; pe.d = m_data; pe.c = m_cnt; m_data = d; m_cnt = 1;
         end else if (m_open) begin
            do_push = 1; pe.d = m_data; pe.c = m_cnt; m_open = 0;
         end
         if (pop) void'(m_q.pop_front());
         if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(pe);
            else begin
               m_ovf = 1;
               if (m_drop != 32'hFFFF_FFFF) m_drop++;
            end
         end
      end
      if (wr && a == 5) m_arm = wd[0];
   endtask

   task automatic sweep();
      i_dbg_wr = 0;
      for (int a = 0; a < 8; a++) begin
         i_dbg_addr = 3'(a);
         #1;
         chk($sformatf("reg%0d", a), o_dbg_rdata, exp_reg(a));
      end
      chk("o_full", {31'b0, o_full}, {31'b0, m_q.size() == DEPTH});
      chk("o_overflow", {31'b0, o_overflow}, {31'b0, m_ovf});
   endtask

   task automatic cycle(input bit en, input logic [31:0] d, input bit wr, input logic [2:0] a, input logic [31:0] wd);
      sweep();
      i_trace_en = en; i_trace_data = d; i_dbg_wr = wr; i_dbg_addr = a; i_dbg_wdata = wd;
      i_dbg_rd = !wr && $urandom_range(0, 1) == 1;
      @(posedge clk);
      model_edge(en, d, wr, a, wd);
      #1;
      i_dbg_wr = 0; i_trace_en = 0; i_dbg_rd = 0;
   endtask

   task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
      i_dbg_wr = 0; i_dbg_addr = a;
      #1;
      chk(name, o_dbg_rdata, exp);
   endtask

   initial begin
      logic [31:0] cur;
      int r;
      bit en, wr;
      logic [2:0] a;
      logic [31:0] wd;
      localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002;
      tbl[0]  = '{1'b0, 32'h0, 1'b1, 3'd5, 32'h1, 3'd5, 32'h1};
      tbl[1]  = '{1'b1, A,     1'b0, 3'd0, 32'h0, 3'd3, 32'h0};
      tbl[2]  = '{1'b1, A,     1'b0, 3'd0, 32'h0, 3'd3, 32'h0};
      tbl[3]  = '{1'b1, A,     1'b0, 3'd0, 32'h0, 3'd3, 32'h0};
      tbl[4]  = '{1'b1, B,     1'b0, 3'd0, 32'h0, 3'd3, 32'h1};
      tbl[5]  = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd3, 32'h2};
      tbl[6]  = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd1, A};
      tbl[7]  = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd2, 32'h3};
      tbl[8]  = '{1'b0, 32'h0, 1'b1, 3'd1, 32'h0, 3'd1, B};
      tbl[9]  = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd2, 32'h1};
      tbl[10] = '{1'b0, 32'h0, 1'b1, 3'd1, 32'h0, 3'd3, 32'h0};
      tbl[11] = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 3'd1, 32'hFFFF_FFFF};
      i_trace_en = 0; i_trace_data = 0; i_dbg_rd = 0; i_dbg_wr = 0; i_dbg_addr = 0; i_dbg_wdata = 0;
      reset = 1;
      model_reset();
      #10;
      sweep();
      reset = 0;

      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].en, tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd);
         rd($sformatf("vec%0d", i), tbl[i].ra, tbl[i].exp);
      end

      cycle(0, 0, 1, 7, 0);
      for (int i = 0; i < 20; i++) cycle(1, 32'h1234_5678, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      rd("sat_level", 3, 32'h2);
      rd("sat_data0", 1, 32'h1234_5678);
      rd("sat_cnt0", 2, 32'd15);
      cycle(0, 0, 1, 1, 0);
      rd("sat_cnt1", 2, 32'd5);

      cycle(0, 0, 1, 7, 0);
      for (int i = 0; i < 6; i++) cycle(1, 32'h100 + i, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("ovf_full", {31'b0, o_full}, 32'h1);
      chk("ovf_flag", {31'b0, o_overflow}, 32'h1);
      rd("ovf_drops", 4, 32'h2);
      rd("ovf_status", 3, 32'h8000_0004);
      rd("ovf_head", 1, 32'h100);

      cycle(1, 32'h200, 0, 0, 0);
      cycle(1, 32'h201, 1, 1, 0);
      rd("pp_status", 3, 32'h8000_0004);
      rd("pp_drops", 4, 32'h2);
      rd("pp_head", 1, 32'h101);
      cycle(0, 0, 0, 0, 0);
      rd("pp_drop_after", 4, 32'h3);

      for (int i = 0; i < 5; i++) cycle(1, 32'h300, 0, 0, 0);
      cycle(0, 0, 1, 7, 0);
      rd("clr_status", 3, 32'h0);
      rd("clr_drops", 4, 32'h0);
      rd("clr_arm", 5, 32'h1);
      chk("clr_ovf", {31'b0, o_overflow}, 32'h0);
      cycle(1, 32'h400, 0, 0, 0);
      rd("clr_open", 3, 32'h0);
      cycle(0, 0, 0, 0, 0);
      rd("clr_newrun", 1, 32'h400);
      rd("clr_newcnt", 2, 32'h1);

      for (int i = 0; i < 6; i++) cycle(1, 32'h500 + i, 0, 0, 0);
      cycle(1, 32'h505, 0, 0, 0);
      #10;
      reset = 1;
      #1;
      chk("rst_full", {31'b0, o_full}, 32'h0);
      chk("rst_ovf", {31'b0, o_overflow}, 32'h0);
      rd("rst_status", 3, 32'h0);
      rd("rst_arm", 5, 32'h0);
      rd("rst_drops", 4, 32'h0);
      rd("rst_head", 1, 32'hFFFF_FFFF);
      model_reset();
      sweep();
      reset = 0;
      cycle(1, 32'h600, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      rd("rst_noarm", 3, 32'h0);

      cur = 32'hC0DE_0000;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 7) == 0) cur = 32'hC0DE_0000 + $urandom_range(0, 2);
         en = $urandom_range(0, 3) != 0;
         wr = $urandom_range(0, 3) == 0;
         r = $urandom_range(0, 15);
         a = r < 8 ? 3'd1 : r < 10 ? 3'd5 : r == 10 ? 3'd7 : 3'($urandom_range(0, 7));
         wd = {$urandom_range(0, 65535), 15'b0, 1'($urandom_range(0, 3) != 0)};
         cycle(en, cur, wr, a, wd);
      end
      sweep();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
